// File: rtl/pc_rx_dispatch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_rx_dispatch_ctrl_if
//  Description : Bundles the RX FIFO read port and the line-buffer write port
//                used by pc_rx_dispatch_ctrl.
//                master : the dispatch controller (drives fifo_rd and wr_*)
//                slave  : the FIFO / line-buffer side
//  Signals     : fifo_empty  RX FIFO empty flag
//                fifo_word   RX FIFO q, valid the cycle after fifo_rd
//                fifo_rd     RX FIFO read strobe (1-cycle pulse)
//                wr_valid    write request to the line buffer
//                wr_addr     write word address (ADDR_WIDTH bits)
//                wr_data     write data (32 bits)
//                wr_ready    line buffer accepts when wr_valid && wr_ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_rx_dispatch_ctrl_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  fifo_empty;
    logic [31:0]           fifo_word;
    logic                  fifo_rd;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  wr_ready;

    modport master (
        input  fifo_empty,
        input  fifo_word,
        input  wr_ready,
        output fifo_rd,
        output wr_valid,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output fifo_empty,
        output fifo_word,
        output wr_ready,
        input  fifo_rd,
        input  wr_valid,
        input  wr_addr,
        input  wr_data
    );
endinterface
`default_nettype wire

// File: rtl/pc_rx_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_rx_dispatch_ctrl
//  Description : Drains 32-bit payload words from the PC_RX receive FIFO and
//                writes them sequentially (address 0, 1, 2, ...) into a
//                word-addressed line buffer. Completion of a packet is
//                signalled only once every payload word has been written.
//  Ports       : i_clock          system clock
//                i_reset_n        synchronous active-low reset
//                i_soft_reset     PC-commanded reset, same effect as reset
//                i_packet_command packet command, sampled with i_packet_done
//                i_packet_done    1-cycle pulse, decoder finished a packet
//                bus              FIFO read + line-buffer write port (master)
//                o_done           1-cycle pulse, packet fully written
//                o_done_command   command of completed packet (held)
//                o_done_count     words written for completed packet (held)
//                o_overflow       sticky, words discarded at MAX_WORDS
//                o_busy           high whenever the FSM is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_rx_dispatch_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WORDS  = 1024
) (
    input  wire                     i_clock,
    input  wire                     i_reset_n,
    input  wire                     i_soft_reset,
    input  wire                     i_packet_command,
    input  wire                     i_packet_done,
    pc_rx_dispatch_ctrl_if.master   bus,
    output logic                    o_done,
    output logic                    o_done_command,
    output logic [ADDR_WIDTH-1:0]   o_done_count,
    output logic                    o_overflow,
    output logic                    o_busy
);

    localparam logic [ADDR_WIDTH-1:0] c_max_words = ADDR_WIDTH'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WRITE   = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t                state_q,      state_d;
    logic [ADDR_WIDTH-1:0] count_q,      count_d;
    logic                  pending_q,    pending_d;
    logic                  cmd_q,        cmd_d;
    logic [31:0]           data_q,       data_d;
    logic                  overflow_q,   overflow_d;
    logic [ADDR_WIDTH-1:0] done_count_q, done_count_d;
    logic                  done_cmd_q,   done_cmd_d;

    logic                  w_fifo_rd;
    logic                  w_wr_valid;
    logic                  w_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_reset_n || i_soft_reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            pending_q    <= 1'b0;
            cmd_q        <= 1'b0;
            data_q       <= '0;
            overflow_q   <= 1'b0;
            done_count_q <= '0;
            done_cmd_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            overflow_q   <= overflow_d;
            done_count_q <= done_count_d;
            done_cmd_q   <= done_cmd_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        pending_d    = pending_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        overflow_d   = overflow_q;
        done_count_d = done_count_q;
        done_cmd_d   = done_cmd_q;
        w_fifo_rd    = 1'b0;
        w_wr_valid   = 1'b0;
        w_done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Draining the FIFO always takes priority over completion, so
                // a packet only finishes once no payload word is left behind.
                if (!bus.fifo_empty) begin
                    state_d = S_RD_REQ;
                end else if (pending_q) begin
                    state_d      = S_FINISH;
                    // Completion values are captured on entry so they are
                    // already valid while o_done is high. A packet_done in
                    // this same cycle merges into the packet being closed.
                    done_count_d = count_q;
                    done_cmd_d   = i_packet_done ? i_packet_command : cmd_q;
                end
            end

            S_RD_REQ: begin
                // The empty check is defensive: nothing else reads the FIFO,
                // so it cannot drain between IDLE and here.
                if (!bus.fifo_empty) begin
                    w_fifo_rd = 1'b1;
                    state_d   = S_RD_WAIT;
                end else begin
                    state_d   = S_IDLE;
                end
            end

            S_RD_WAIT: begin
                if (count_q < c_max_words) begin
                    data_d  = bus.fifo_word;
                    state_d = S_WRITE;
                end else begin
                    overflow_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            S_WRITE: begin
                w_wr_valid = 1'b1;
                if (bus.wr_ready) begin
                    // count_q < MAX_WORDS here, so this cannot pass the cap.
                    count_d = count_q + ADDR_WIDTH'(1);
                    state_d = S_IDLE;
                end
            end

            S_FINISH: begin
                w_done    = 1'b1;
                count_d   = '0;
                pending_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A packet boundary in any state, including FINISH, opens (or
        // merges into) the pending packet; it overrides the FINISH clear.
        if (i_packet_done) begin
            pending_d = 1'b1;
            cmd_d     = i_packet_command;
        end
    end

    assign bus.fifo_rd     = w_fifo_rd;
    assign bus.wr_valid    = w_wr_valid;
    assign bus.wr_addr     = count_q;
    assign bus.wr_data     = data_q;

    assign o_done          = w_done;
    assign o_done_command  = done_cmd_q;
    assign o_done_count    = done_count_q;
    assign o_overflow      = overflow_q;
    assign o_busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pc_rx_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_rx_dispatch_ctrl
//  Description : Directed self-checking bench for pc_rx_dispatch_ctrl, with a
//                small RX FIFO model and a line-buffer write monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_rx_dispatch_ctrl;

    localparam int AW = 16;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          soft_rst;
    logic          pkt_cmd;
    logic          pkt_done;
    logic          done;
    logic          done_cmd;
    logic [AW-1:0] done_count;
    logic          overflow;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_rx_dispatch_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    pc_rx_dispatch_ctrl #(
        .ADDR_WIDTH (AW),
        .MAX_WORDS  (MW)
    ) dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_soft_reset     (soft_rst),
        .i_packet_command (pkt_cmd),
        .i_packet_done    (pkt_done),
        .bus              (bus),
        .o_done           (done),
        .o_done_command   (done_cmd),
        .o_done_count     (done_count),
        .o_overflow       (overflow),
        .o_busy           (busy)
    );

    // ---------------- RX FIFO model (normal mode, q valid after read) ------
    logic [31:0] mem [0:15];
    logic [31:0] fifo_q = 32'h0;
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          n_rd   = 0;
    int          n_bad_rd = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.fifo_word  = fifo_q;

    // ---------------- line-buffer write monitor ----------------------------
    logic [AW-1:0] wr_addr_log [0:63];
    logic [31:0]   wr_data_log [0:63];
    int            n_wr   = 0;
    int            n_done = 0;

    always @(posedge clk) begin
        if (bus.fifo_rd) begin
            if (wr_ptr == rd_ptr) n_bad_rd <= n_bad_rd + 1;
            fifo_q <= mem[rd_ptr % 16];
            rd_ptr <= rd_ptr + 1;
            n_rd   <= n_rd + 1;
        end
        if (bus.wr_valid && bus.wr_ready) begin
            wr_addr_log[n_wr % 64] <= bus.wr_addr;
            wr_data_log[n_wr % 64] <= bus.wr_data;
            n_wr <= n_wr + 1;
        end
        if (done) n_done <= n_done + 1;
    end

    // ---------------- helpers ----------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic pulse_done(input logic cmd);
        pkt_cmd  = cmd;
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
    endtask

    task automatic wait_writes(input int target, input string tag);
        int k;
        k = 0;
        while (n_wr < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(n_wr >= target), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ------------------------------------
    initial begin
        int base_wr;
        int base_rd;
        int base_done;
        int k;
        logic found;

        rst_n        = 1'b0;
        soft_rst     = 1'b0;
        pkt_cmd      = 1'b0;
        pkt_done     = 1'b0;
        bus.wr_ready = 1'b1;

        // T1: reset held with FIFO non-empty
        push(32'h0000_0055);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("T1 no rd in reset", 64'(bus.fifo_rd), 64'd0);
        end
        chk("T1 ctl outputs", 64'({done, done_cmd, overflow, busy, bus.wr_valid}), 64'd0);
        chk("T1 count/addr", 64'({done_count, bus.wr_addr}), 64'd0);
        chk("T1 wr_data", 64'(bus.wr_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("T1 rd after release", 64'(bus.fifo_rd), 64'd1);
        @(negedge clk);
        chk("T1 rd single cycle", 64'(bus.fifo_rd), 64'd0);
        wait_writes(1, "T1 word written");
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        @(negedge clk);

        // Zero-payload packet: o_done two cycles after i_packet_done
        base_done = n_done;
        pkt_cmd  = 1'b1;
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("Z no done at +1", 64'(done), 64'd0);
        @(negedge clk);
        chk("Z done at +2", 64'(done), 64'd1);
        chk("Z count", 64'(done_count), 64'd0);
        chk("Z cmd", 64'(done_cmd), 64'd1);
        @(negedge clk);
        chk("Z pulse ends", 64'(done), 64'd0);

        // T2: single packet of 3 words
        base_wr   = n_wr;
        push(32'h0000_00A1);
        push(32'h0000_00A2);
        push(32'h0000_00A3);
        wait_writes(base_wr + 3, "T2 writes");
        for (int i = 0; i < 3; i++) begin
            chk("T2 addr", 64'(wr_addr_log[(base_wr + i) % 64]), 64'(i));
            chk("T2 data", 64'(wr_data_log[(base_wr + i) % 64]), 64'(32'hA1 + i));
        end
        base_done = n_done;
        pulse_done(1'b1);
        wait_done("T2 done seen");
        chk("T2 count", 64'(done_count), 64'd3);
        chk("T2 cmd", 64'(done_cmd), 64'd1);
        repeat (6) @(negedge clk);
        chk("T2 one pulse", 64'(n_done - base_done), 64'd1);

        // T3: backpressure on word 2
        base_wr = n_wr;
        push(32'h0000_00B1);
        push(32'h0000_00B2);
        push(32'h0000_00B3);
        found = 1'b0;
        k = 0;
        while (!found && k < 100) begin
            @(negedge clk);
            if (bus.wr_valid && bus.wr_addr == AW'(1)) found = 1'b1;
            k++;
        end
        chk("T3 reached word2", 64'(found), 64'd1);
        bus.wr_ready = 1'b0;
        base_rd = n_rd;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("T3 held", 64'({bus.wr_valid, bus.wr_addr, bus.wr_data}),
                64'({1'b1, 16'd1, 32'h0000_00B2}));
        end
        chk("T3 no extra rd", 64'(n_rd - base_rd), 64'd0);
        bus.wr_ready = 1'b1;
        wait_writes(base_wr + 3, "T3 writes");
        chk("T3 word3 addr", 64'(wr_addr_log[(base_wr + 2) % 64]), 64'd2);
        chk("T3 word3 data", 64'(wr_data_log[(base_wr + 2) % 64]), 64'h0000_00B3);
        pulse_done(1'b0);
        wait_done("T3 done seen");
        chk("T3 count", 64'(done_count), 64'd3);
        chk("T3 cmd", 64'(done_cmd), 64'd0);
        @(negedge clk);

        // T4: packet_done while 2 words still queued
        base_wr = n_wr;
        push(32'h0000_00C1);
        push(32'h0000_00C2);
        pulse_done(1'b1);
        wait_done("T4 done seen");
        chk("T4 writes before done", 64'(n_wr - base_wr), 64'd2);
        chk("T4 count", 64'(done_count), 64'd2);
        chk("T4 cmd", 64'(done_cmd), 64'd1);
        chk("T4 word2 data", 64'(wr_data_log[(base_wr + 1) % 64]), 64'h0000_00C2);
        @(negedge clk);

        // T5: overflow, MAX_WORDS = 4, 6 words
        chk("T5 overflow clear", 64'(overflow), 64'd0);
        base_wr = n_wr;
        base_rd = n_rd;
        for (int i = 0; i < 6; i++) push(32'h0000_00D0 + 32'(i));
        k = 0;
        while ((n_rd - base_rd) < 6 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("T5 fifo reads", 64'(n_rd - base_rd), 64'd6);
        chk("T5 overflow set", 64'(overflow), 64'd1);
        pulse_done(1'b0);
        wait_done("T5 done seen");
        chk("T5 count", 64'(done_count), 64'd4);
        chk("T5 writes", 64'(n_wr - base_wr), 64'd4);
        chk("T5 last addr", 64'(wr_addr_log[(base_wr + 3) % 64]), 64'd3);
        chk("T5 last data", 64'(wr_data_log[(base_wr + 3) % 64]), 64'h0000_00D3);
        @(negedge clk);
        chk("T5 overflow sticky", 64'(overflow), 64'd1);

        // T6: soft reset while stalled in WRITE
        base_done = n_done;
        base_wr   = n_wr;
        pulse_done(1'b1);
        push(32'h0000_00E0);
        wait_writes(base_wr + 1, "T6 first write");
        bus.wr_ready = 1'b0;
        push(32'h0000_00E1);
        found = 1'b0;
        k = 0;
        while (!found && k < 100) begin
            @(negedge clk);
            if (bus.wr_valid) found = 1'b1;
            k++;
        end
        chk("T6 stalled write", 64'({found, bus.wr_addr, busy}), 64'({1'b1, 16'd1, 1'b1}));
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        chk("T6 ctl after reset", 64'({bus.wr_valid, busy, overflow, done}), 64'd0);
        chk("T6 addr after reset", 64'(bus.wr_addr), 64'd0);
        repeat (10) @(negedge clk);
        chk("T6 no done", 64'(n_done - base_done), 64'd0);
        bus.wr_ready = 1'b1;

        chk("no rd while empty", 64'(n_bad_rd), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
